// File: rtl/aes192_pkg.sv
// aes192_pkg: shared state codes and sizes for the AES-192 stream loader
package aes192_pkg;
  localparam int KEY_WORDS = 6;
  localparam int DATA_WORDS = 4;
  localparam int WORD_W = 32;
  localparam int KEY_W = 192;
  localparam int BLK_W = 128;
  typedef logic [1:0] state_t;
  localparam state_t LOAD = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/aes192_word_packer.sv
// aes192_word_packer: N-word MSW-first packer with word count and full flag
module aes192_word_packer #(
  parameter int N = 4,
  parameter int W = 32,
  parameter bit WRAP = 1'b0,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           load,
  input  logic [W-1:0]   word,
  output logic [N*W-1:0] data,
  output logic [CW-1:0]  cnt,
  output logic           full
);
  // WRAP: count returns to 0 after the last word (key); otherwise it parks at N (data)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt <= '0;
      full <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      full <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < N; i++)
        if (cnt == CW'(i)) data[(N-1-i)*W +: W] <= word;
      full <= (cnt == CW'(N - 1)) ? 1'b1 : (cnt == '0) ? 1'b0 : full;
      cnt <= (cnt == CW'(N - 1)) ? (WRAP ? '0 : CW'(N)) : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/aes192_stream_loader.sv
// aes192_stream_loader: word-stream key/block loader and settle/capture stage for a combinational AES-192 core.
// Optional AES192_BLOCK_CNT_EN adds a 32-bit count of delivered ciphertext blocks.
module aes192_stream_loader
  import aes192_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_key,
  input  logic [WORD_W-1:0] in_data,
  output logic [BLK_W-1:0] core_datain,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             key_loaded,
  output logic             busy
`ifdef AES192_BLOCK_CNT_EN
  ,
  output logic [31:0]      block_count
`endif
);
  state_t state;
  logic [CNT_W-1:0] settle_cnt;
  logic [2:0] key_cnt, data_cnt;
  logic data_full, key_ld, dat_ld, hs, go;
  assign in_ready = (state == LOAD) && (in_is_key || !data_full);
  assign key_ld = in_valid && in_ready && in_is_key;
  assign dat_ld = in_valid && in_ready && !in_is_key;
  assign hs = out_valid && out_ready;
  assign busy = state != LOAD;
  // Look at next-cycle flags so SETTLE starts right after the completing word,
  // and a key word 0 arriving with a full block holds off the transition.
  assign go = (data_full || (dat_ld && data_cnt == 3'(DATA_WORDS - 1)))
           && (key_ld ? (key_cnt == 3'(KEY_WORDS - 1)) : key_loaded);
  aes192_word_packer #(.N(KEY_WORDS), .W(WORD_W), .WRAP(1'b1), .CW(3)) u_key (
    .clk(clk), .rst(rst), .clr(1'b0), .load(key_ld), .word(in_data),
    .data(core_key), .cnt(key_cnt), .full(key_loaded)
  );
  aes192_word_packer #(.N(DATA_WORDS), .W(WORD_W), .WRAP(1'b0), .CW(3)) u_data (
    .clk(clk), .rst(rst), .clr(hs), .load(dat_ld), .word(in_data),
    .data(core_datain), .cnt(data_cnt), .full(data_full)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      settle_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (state == LOAD && go) begin
      state <= SETTLE;
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
      if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
        out_data <= core_out;
        out_valid <= 1'b1;
        state <= DONE;
      end
    end else if (state == DONE && hs) begin
      out_valid <= 1'b0;
      state <= LOAD;
    end
  end
`ifdef AES192_BLOCK_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) block_count <= '0;
    else if (hs) block_count <= block_count + 1'b1;
`endif
endmodule
